immgen_pipe: RTL and testbench

- Parametrised, pipelined immediate generator for the decode stage of the RISC-V core.
- Takes one instruction word per valid/ready handshake and produces the sign-extended XLEN immediate, a format code and an illegal flag one cycle later.
- Uses an output register plus a skid register, so upstream fetch and downstream execute can both stall without losing or repeating an instruction.
- Supports RV32 and RV64 via XLEN, and handles shift-amount immediates.

---
 rtl/immgen_pipe.sv | 172 +++++++++++++++++
 tb/tb_immgen_pipe.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/immgen_pipe.sv
// Pipelined RISC-V immediate generator: decode -> output register + skid register.
// Optional macro IMMGEN_ZICSR_EN decodes CSR*I encodings as ZIMM (format code 7).
module immgen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [31:0]     inst,
    output logic            imm_valid,
    input  logic            imm_ready,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_fmt,
    output logic            illegal
);

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ZIMM  = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } dec_t;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("immgen_pipe: XLEN must be 32 or 64");
    end

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    dec_t w_dec;
    logic w_is_shamt;

    assign w_is_shamt = (inst[13:12] == 2'b01);  // funct3 001 (SLLI) or 101 (SRLI/SRAI)

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_dec = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};
        case (inst[6:0])
            7'b0000011, 7'b0001111, 7'b1100111: begin
                w_dec.fmt = FMT_I;
                w_dec.imm = sext32({{20{inst[31]}}, inst[31:20]});
            end
            7'b0010011: begin
                if (w_is_shamt) begin
                    w_dec.fmt = FMT_SHAMT;
                    if (XLEN == 64) begin
                        w_dec.imm = XLEN'(inst[25:20]);
                    end else begin
                        w_dec.imm     = XLEN'(inst[24:20]);
                        w_dec.illegal = inst[25];
                    end
                end else begin
                    w_dec.fmt = FMT_I;
                    w_dec.imm = sext32({{20{inst[31]}}, inst[31:20]});
                end
            end
            7'b0100011: begin
                w_dec.fmt = FMT_S;
                w_dec.imm = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
            end
            7'b1100011: begin
                w_dec.fmt = FMT_B;
                w_dec.imm = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
            end
            7'b0110111, 7'b0010111: begin
                w_dec.fmt = FMT_U;
                w_dec.imm = sext32({inst[31:12], 12'b0});
            end
            7'b1101111: begin
                w_dec.fmt = FMT_J;
                w_dec.imm = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
            end
            7'b0110011: begin
                w_dec.fmt = FMT_NONE;
            end
            7'b1110011: begin
`ifdef IMMGEN_ZICSR_EN
                if (inst[14]) begin
                    w_dec.fmt = FMT_ZIMM;
                    w_dec.imm = XLEN'(inst[19:15]);
                end else begin
                    w_dec.fmt = FMT_I;
                    w_dec.imm = sext32({{20{inst[31]}}, inst[31:20]});
                end
`else
                w_dec.fmt = FMT_I;
                w_dec.imm = sext32({{20{inst[31]}}, inst[31:20]});
`endif
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    if (w_is_shamt) begin
                        w_dec.fmt     = FMT_SHAMT;
                        w_dec.imm     = XLEN'(inst[24:20]);
                        w_dec.illegal = inst[25];
                    end else begin
                        w_dec.fmt = FMT_I;
                        w_dec.imm = sext32({{20{inst[31]}}, inst[31:20]});
                    end
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            7'b0111011: begin
                w_dec.illegal = (XLEN != 64);
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    dec_t r_out;
    dec_t r_skid;
    logic r_out_valid;
    logic r_skid_valid;
    logic w_accept;
    logic w_out_load;

    assign inst_ready = !r_skid_valid;
    assign w_accept   = inst_valid && inst_ready;
    assign w_out_load = !r_out_valid || imm_ready;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out        <= '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};
            r_skid       <= '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_load) begin
            // The skid entry is always older than anything upstream, and no accept can
            // happen while it is occupied, so draining it first keeps FIFO order.
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out       <= w_dec;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign imm_valid = r_out_valid;
    assign imm       = r_out.imm;
    assign imm_fmt   = r_out.fmt;
    assign illegal   = r_out.illegal;

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_immgen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst;
    logic        imm_ready;

    logic        ready32, valid32, ill32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ready64, valid64, ill64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;

    int checks = 0;
    int errors = 0;

    immgen_pipe #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .inst_valid(inst_valid), .inst_ready(ready32), .inst(inst),
        .imm_valid(valid32), .imm_ready(imm_ready),
        .imm(imm32), .imm_fmt(fmt32), .illegal(ill32)
    );

    immgen_pipe #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .inst_valid(inst_valid), .inst_ready(ready64), .inst(inst),
        .imm_valid(valid64), .imm_ready(imm_ready),
        .imm(imm64), .imm_fmt(fmt64), .illegal(ill64)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic out32(input string tag, input logic [31:0] e_imm, input logic [2:0] e_fmt,
                         input logic e_ill);
        check({tag, ".valid"}, 64'(valid32), 64'd1);
        check({tag, ".imm"}, 64'(imm32), 64'(e_imm));
        check({tag, ".fmt"}, 64'(fmt32), 64'(e_fmt));
        check({tag, ".ill"}, 64'(ill32), 64'(e_ill));
    endtask

    task automatic send(input logic [31:0] w);
        inst_valid = 1'b1;
        inst       = w;
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        inst_valid = 1'b0;
        inst       = '0;
        imm_ready  = 1'b1;

        #1;
        check("rst.valid", 64'(valid32), 64'd0);
        check("rst.imm", 64'(imm32), 64'd0);
        check("rst.fmt", 64'(fmt32), 64'd0);
        check("rst.ill", 64'(ill32), 64'd0);
        #6 rst_n = 1'b1;
        tick();
        check("post_rst.ready", 64'(ready32), 64'd1);
        check("post_rst.valid", 64'(valid32), 64'd0);

        // Back-to-back, imm_ready held high
        send(32'h00500093); tick(); out32("b2b0", 32'h00000005, 3'd1, 1'b0);
        check("b2b0.ready", 64'(ready32), 64'd1);
        send(32'hfff00093); tick(); out32("b2b1", 32'hffffffff, 3'd1, 1'b0);
        check("b2b1.imm64", imm64, 64'hffffffffffffffff);
        send(32'h00102223); tick(); out32("b2b2", 32'h00000004, 3'd2, 1'b0);
        send(32'h00000463); tick(); out32("b2b3", 32'h00000008, 3'd3, 1'b0);
        send(32'h123450b7); tick(); out32("b2b4", 32'h12345000, 3'd4, 1'b0);
        send(32'h008000ef); tick(); out32("b2b5", 32'h00000008, 3'd5, 1'b0);
        inst_valid = 1'b0; tick();
        check("b2b.drain", 64'(valid32), 64'd0);

        // XLEN=64 specifics and the XLEN=32 illegal-shamt counterpart
        send(32'h800000b7); tick();
        check("x64.lui.imm", imm64, 64'hffffffff80000000);
        check("x64.lui.fmt", 64'(fmt64), 64'd4);
        send(32'h02009093); tick();
        check("x64.slli32.imm", imm64, 64'h0000000000000020);
        check("x64.slli32.fmt", 64'(fmt64), 64'd6);
        check("x64.slli32.ill", 64'(ill64), 64'd0);
        check("x32.slli32.ill", 64'(ill32), 64'd1);
        send(32'h0000001b); tick();
        check("x32.opimm32.ill", 64'(ill32), 64'd1);
        check("x64.opimm32.ill", 64'(ill64), 64'd0);

        // Illegal opcode and a legal shamt
        send(32'h00000000); tick(); out32("illegal0", 32'h0, 3'd0, 1'b1);
        send(32'h00309093); tick(); out32("slli3", 32'h00000003, 3'd6, 1'b0);

        // CSRRWI-style SYSTEM encoding
        send(32'h3002d0f3); tick();
`ifdef IMMGEN_ZICSR_EN
        out32("zimm", 32'h00000005, 3'd7, 1'b0);
`else
        out32("zimm_off", 32'h00000300, 3'd1, 1'b0);
`endif
        inst_valid = 1'b0; tick();

        // Backpressure: fill output then skid, then release
        imm_ready = 1'b0;
        send(32'h00500093); tick(); out32("bp0", 32'h00000005, 3'd1, 1'b0);
        check("bp0.ready", 64'(ready32), 64'd1);
        send(32'h00102223); tick(); out32("bp1.hold", 32'h00000005, 3'd1, 1'b0);
        check("bp1.ready", 64'(ready32), 64'd0);
        inst_valid = 1'b0; tick(); out32("bp2.hold", 32'h00000005, 3'd1, 1'b0);
        imm_ready = 1'b1; tick(); out32("bp3.skid", 32'h00000004, 3'd2, 1'b0);
        check("bp3.ready", 64'(ready32), 64'd1);
        tick();
        check("bp4.empty", 64'(valid32), 64'd0);

        // Flush with skid full and a simultaneous valid instruction
        imm_ready = 1'b0;
        send(32'h00500093); tick();
        send(32'h00102223); tick();
        check("fl.skidfull", 64'(ready32), 64'd0);
        send(32'h123450b7); flush = 1'b1; tick();
        check("fl.valid", 64'(valid32), 64'd0);
        check("fl.ready", 64'(ready32), 64'd1);
        flush = 1'b0; inst_valid = 1'b0; imm_ready = 1'b1; tick();
        check("fl.none", 64'(valid32), 64'd0);
        tick();
        check("fl.none2", 64'(valid32), 64'd0);

        // Asynchronous reset in the middle of a stall
        imm_ready = 1'b0;
        send(32'hfff00093); tick();
        send(32'h123450b7); tick();
        inst_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst.valid", 64'(valid32), 64'd0);
        check("arst.imm", 64'(imm32), 64'd0);
        check("arst.fmt", 64'(fmt32), 64'd0);
        check("arst.ill", 64'(ill32), 64'd0);
        check("arst.imm64", imm64, 64'd0);
        #2 rst_n = 1'b1;
        imm_ready = 1'b1;
        tick();
        check("arst.ready", 64'(ready32), 64'd1);
        check("arst.novalid", 64'(valid32), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
